// File: rtl/uart_cmd_client.sv
`default_nettype none
// ============================================================================
//  Module      : uart_cmd_client
//  Description : Host-side initiator for the cmd_server serial protocol.
//                Accepts one OPB read/write request on a valid/ready
//                handshake and sends it as a 10-byte 8N1 command frame:
//                  H, ADDR[31:24..7:0], WDATA[31:24..7:0], ~H
//                where H = 0x5A (write) or 0x5B (read). It then collects
//                the 10-byte reply, checks header/address/trailer, and
//                returns the reply data field together with a status code.
//
//  Ports       : SYS_CLK    in   system clock
//                SYS_RST    in   synchronous active-high reset
//                CMD_VALID  in   request valid
//                CMD_READY  out  idle, request can be accepted
//                CMD_RW     in   0 = write, 1 = read
//                CMD_ADDR   in   [31:0] OPB address
//                CMD_WDATA  in   [31:0] write data (sent on reads too)
//                RSP_VALID  out  one-cycle response strobe
//                RSP_DATA   out  [31:0] reply data field
//                RSP_ERR    out  [1:0] 0 ok, 1 timeout, 2 frame error
//                UART_TXD   out  serial out, idle high
//                UART_RXD   in   serial in, asynchronous
//
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_client #(
    parameter int CLKS_PER_BIT = 868,
    parameter int TIMEOUT_CLKS = 2000000
) (
    input  logic        SYS_CLK,
    input  logic        SYS_RST,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic        CMD_RW,
    input  logic [31:0] CMD_ADDR,
    input  logic [31:0] CMD_WDATA,
    output logic        RSP_VALID,
    output logic [31:0] RSP_DATA,
    output logic [1:0]  RSP_ERR,
    output logic        UART_TXD,
    input  logic        UART_RXD
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int              c_BW        = $clog2(CLKS_PER_BIT + 1);
    localparam logic [c_BW-1:0] c_BIT_LAST  = c_BW'(CLKS_PER_BIT - 1);
    localparam logic [c_BW-1:0] c_HALF_LAST = c_BW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_BW-1:0] c_CNT_ONE   = c_BW'(1);
    localparam logic [31:0]     c_TO_LAST   = 32'(TIMEOUT_CLKS - 1);

    localparam logic [1:0] c_ERR_OK      = 2'd0;
    localparam logic [1:0] c_ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] c_ERR_FRAME   = 2'd2;

    // Header is 0x5A for writes and 0x5B for reads: upper seven bits fixed
    localparam logic [6:0] c_HDR_UPPER = 7'b0101101;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_SEND = 2'd1;
    localparam logic [1:0] c_ST_WAIT = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [1:0]      r_state;
    logic [1:0]      w_state_next;

    logic            r_rw;
    logic [31:0]     r_addr;
    logic [31:0]     r_wdata;
    logic [7:0]      w_hdr;
    logic            w_accept;

    logic            r_txd;
    logic [8:0]      r_tx_shift;
    logic [c_BW-1:0] r_tx_cnt;
    logic [3:0]      r_tx_bit;
    logic [3:0]      r_tx_byte;
    logic [3:0]      w_tx_idx_next;
    logic [7:0]      w_tx_next_byte;
    logic            w_tx_last;

    logic            r_rx_meta;
    logic            r_rx_sync;
    logic            r_rx_prev;
    logic            r_rx_busy;
    logic [c_BW-1:0] r_rx_cnt;
    logic [3:0]      r_rx_bit;
    logic [7:0]      r_rx_shift;
    logic [3:0]      r_rx_count;
    logic            w_rx_done;
    logic            w_rx_final;
    logic [7:0]      w_rx_expect;
    logic            w_rx_check;
    logic            w_byte_bad;

    logic [31:0]     r_to_cnt;
    logic            w_timeout;
    logic [1:0]      r_acc_err;
    logic [31:0]     r_acc_data;
    logic [1:0]      w_err_final;
    logic [31:0]     r_rsp_data;
    logic [1:0]      r_rsp_err;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    assign w_accept = CMD_VALID && (r_state == c_ST_IDLE);

    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: if (CMD_VALID) w_state_next = c_ST_SEND;
            c_ST_SEND: if (w_tx_last) w_state_next = c_ST_WAIT;
            // A completing reply and an expiring timeout both end the wait;
            // which status is reported is settled in the response register.
            c_ST_WAIT: if (w_rx_final || w_timeout) w_state_next = c_ST_DONE;
            default:   w_state_next = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch
    // ------------------------------------------------------------------
    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST) begin
            r_rw    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_rw    <= CMD_RW;
            r_addr  <= CMD_ADDR;
            r_wdata <= CMD_WDATA;
        end
    end

    assign w_hdr = {c_HDR_UPPER, r_rw};

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    // Byte 0 is loaded straight from CMD_RW at acceptance; bytes 1..9 are
    // picked from the latched request as each previous stop bit ends.
    always_comb begin
        w_tx_idx_next  = r_tx_byte + 4'd1;
        w_tx_next_byte = ~w_hdr;
        case (w_tx_idx_next)
            4'd1:    w_tx_next_byte = r_addr[31:24];
            4'd2:    w_tx_next_byte = r_addr[23:16];
            4'd3:    w_tx_next_byte = r_addr[15:8];
            4'd4:    w_tx_next_byte = r_addr[7:0];
            4'd5:    w_tx_next_byte = r_wdata[31:24];
            4'd6:    w_tx_next_byte = r_wdata[23:16];
            4'd7:    w_tx_next_byte = r_wdata[15:8];
            4'd8:    w_tx_next_byte = r_wdata[7:0];
            default: w_tx_next_byte = ~w_hdr;
        endcase
    end

    // Last cycle of the final stop bit
    assign w_tx_last = (r_state == c_ST_SEND) && (r_tx_cnt == c_BIT_LAST) &&
                       (r_tx_bit == 4'd9) && (r_tx_byte == 4'd9);

    // r_tx_bit: 0 = start, 1..8 = data, 9 = stop. r_tx_shift holds the
    // not-yet-sent data bits plus the stop bit, shifted out LSB first.
    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST) begin
            r_txd      <= 1'b1;
            r_tx_shift <= '1;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_byte  <= '0;
        end else if (w_accept) begin
            r_txd      <= 1'b0;
            r_tx_shift <= {1'b1, c_HDR_UPPER, CMD_RW};
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_byte  <= '0;
        end else if (r_state == c_ST_SEND) begin
            if (r_tx_cnt == c_BIT_LAST) begin
                r_tx_cnt <= '0;
                if (r_tx_bit == 4'd9) begin
                    if (r_tx_byte == 4'd9) begin
                        r_txd <= 1'b1;
                    end else begin
                        // Next start bit follows the stop bit with no gap
                        r_txd      <= 1'b0;
                        r_tx_shift <= {1'b1, w_tx_next_byte};
                        r_tx_bit   <= '0;
                        r_tx_byte  <= w_tx_idx_next;
                    end
                end else begin
                    r_txd      <= r_tx_shift[0];
                    r_tx_shift <= {1'b1, r_tx_shift[8:1]};
                    r_tx_bit   <= r_tx_bit + 4'd1;
                end
            end else begin
                r_tx_cnt <= r_tx_cnt + c_CNT_ONE;
            end
        end else begin
            r_txd <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= UART_RXD;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    // Held idle with a cleared byte count outside the reply window, so
    // line activity at other times can never be mistaken for reply bytes.
    // A falling edge arms the receiver; the start bit must still be low at
    // half-bit, which rejects short glitches. Later samples are taken one
    // full bit apart, i.e. at bit centres.
    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST || (r_state != c_ST_WAIT)) begin
            r_rx_busy  <= 1'b0;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_count <= '0;
        end else if (!r_rx_busy) begin
            if (r_rx_prev && !r_rx_sync) begin
                r_rx_busy <= 1'b1;
                r_rx_cnt  <= '0;
                r_rx_bit  <= '0;
            end
        end else if (r_rx_bit == 4'd0) begin
            if (r_rx_cnt == c_HALF_LAST) begin
                r_rx_cnt <= '0;
                if (r_rx_sync) begin
                    r_rx_busy <= 1'b0;
                end else begin
                    r_rx_bit <= 4'd1;
                end
            end else begin
                r_rx_cnt <= r_rx_cnt + c_CNT_ONE;
            end
        end else if (r_rx_cnt == c_BIT_LAST) begin
            r_rx_cnt <= '0;
            if (r_rx_bit == 4'd9) begin
                // Stop-bit centre: byte is complete, valid stop or not
                r_rx_busy  <= 1'b0;
                r_rx_count <= r_rx_count + 4'd1;
            end else begin
                r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
                r_rx_bit   <= r_rx_bit + 4'd1;
            end
        end else begin
            r_rx_cnt <= r_rx_cnt + c_CNT_ONE;
        end
    end

    assign w_rx_done  = r_rx_busy && (r_rx_bit == 4'd9) && (r_rx_cnt == c_BIT_LAST);
    assign w_rx_final = w_rx_done && (r_rx_count == 4'd9);

    // Expected value of the byte now completing; data bytes 5..8 are free
    always_comb begin
        w_rx_expect = 8'h00;
        w_rx_check  = 1'b1;
        case (r_rx_count)
            4'd0:    w_rx_expect = w_hdr;
            4'd1:    w_rx_expect = r_addr[31:24];
            4'd2:    w_rx_expect = r_addr[23:16];
            4'd3:    w_rx_expect = r_addr[15:8];
            4'd4:    w_rx_expect = r_addr[7:0];
            4'd9:    w_rx_expect = ~w_hdr;
            default: w_rx_check  = 1'b0;
        endcase
    end

    // r_rx_sync is the stop-bit sample on the completing cycle
    assign w_byte_bad = !r_rx_sync || (w_rx_check && (r_rx_shift != w_rx_expect));

    // ------------------------------------------------------------------
    // Timeout, reply checking and response registers
    // ------------------------------------------------------------------
    assign w_timeout   = (r_state == c_ST_WAIT) && (r_to_cnt == c_TO_LAST);
    assign w_err_final = (r_acc_err != c_ERR_OK) ? r_acc_err :
                         (w_byte_bad ? c_ERR_FRAME : c_ERR_OK);

    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST) begin
            r_to_cnt   <= '0;
            r_acc_err  <= c_ERR_OK;
            r_acc_data <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= c_ERR_OK;
        end else begin
            if (r_state == c_ST_WAIT) begin
                r_to_cnt <= r_to_cnt + 32'd1;
            end else begin
                r_to_cnt <= '0;
            end

            if (w_accept) begin
                r_acc_err  <= c_ERR_OK;
                r_acc_data <= '0;
            end

            if (w_rx_done) begin
                // Only the first error of a frame is kept
                if ((r_acc_err == c_ERR_OK) && w_byte_bad) begin
                    r_acc_err <= c_ERR_FRAME;
                end
                if (!w_rx_check) begin
                    r_acc_data <= {r_acc_data[23:0], r_rx_shift};
                end
            end

            // Completion takes priority over a timeout on the same cycle
            if (w_rx_final) begin
                r_rsp_err  <= w_err_final;
                r_rsp_data <= r_acc_data;
            end else if (w_timeout) begin
                r_rsp_err  <= (r_acc_err != c_ERR_OK) ? r_acc_err : c_ERR_TIMEOUT;
                r_rsp_data <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign CMD_READY = (r_state == c_ST_IDLE);
    assign RSP_VALID = (r_state == c_ST_DONE);
    assign RSP_DATA  = r_rsp_data;
    assign RSP_ERR   = r_rsp_err;
    assign UART_TXD  = r_txd;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_client.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_cmd_client
//  Description : Directed self-checking bench for uart_cmd_client. Checks
//                TX framing and bit timing, reply decoding, timeout latency,
//                error reporting, glitch rejection and mid-frame reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_client;

    localparam int CPB = 16;
    localparam int TO  = 10000;

    typedef logic [7:0] frame_t [10];

    logic        SYS_CLK   = 1'b0;
    logic        SYS_RST   = 1'b1;
    logic        CMD_VALID = 1'b0;
    logic        CMD_RW    = 1'b0;
    logic [31:0] CMD_ADDR  = '0;
    logic [31:0] CMD_WDATA = '0;
    logic        UART_RXD  = 1'b1;
    logic        CMD_READY;
    logic        RSP_VALID;
    logic [31:0] RSP_DATA;
    logic [1:0]  RSP_ERR;
    logic        UART_TXD;

    int cyc   = 0;
    int n_cmp = 0;
    int n_bad = 0;

    uart_cmd_client #(
        .CLKS_PER_BIT (CPB),
        .TIMEOUT_CLKS (TO)
    ) dut (
        .SYS_CLK   (SYS_CLK),
        .SYS_RST   (SYS_RST),
        .CMD_VALID (CMD_VALID),
        .CMD_READY (CMD_READY),
        .CMD_RW    (CMD_RW),
        .CMD_ADDR  (CMD_ADDR),
        .CMD_WDATA (CMD_WDATA),
        .RSP_VALID (RSP_VALID),
        .RSP_DATA  (RSP_DATA),
        .RSP_ERR   (RSP_ERR),
        .UART_TXD  (UART_TXD),
        .UART_RXD  (UART_RXD)
    );

    always #5 SYS_CLK = ~SYS_CLK;
    always @(posedge SYS_CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // All bench activity sits on falling edges; cyc is the current cycle
    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge SYS_CLK);
    endtask

    // Drive one request; a = cycle in which VALID & READY are both high
    task automatic issue(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                         output int a);
        int n;
        n = 0;
        while (CMD_READY !== 1'b1 && n < 50000) begin
            @(negedge SYS_CLK);
            n++;
        end
        chk("issue_ready", CMD_READY, 1'b1);
        CMD_VALID = 1'b1;
        CMD_RW    = rw;
        CMD_ADDR  = addr;
        CMD_WDATA = wdata;
        a = cyc;
        @(negedge SYS_CLK);
        // Scramble inputs so any failure to latch shows up in the frame
        CMD_VALID = 1'b0;
        CMD_RW    = ~rw;
        CMD_ADDR  = ~addr;
        CMD_WDATA = ~wdata;
        chk("ready_drop", CMD_READY, 1'b0);
    endtask

    // Sample the first and last cycle of every bit of every byte
    task automatic check_frame(input int a, input frame_t f, input string tag);
        logic [9:0] first;
        logic [9:0] last;
        logic [9:0] want;
        int s;
        for (int b = 0; b < 10; b++) begin
            for (int i = 0; i < 10; i++) begin
                s = a + 1 + (b * 10 + i) * CPB;
                wait_cyc(s);
                first[i] = UART_TXD;
                wait_cyc(s + CPB - 1);
                last[i] = UART_TXD;
            end
            want = {1'b1, f[b], 1'b0};
            chk($sformatf("%s_tx_byte%0d", tag, b), {12'h0, last, first}, {12'h0, want, want});
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop, input logic hold_stop);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            UART_RXD = bits[i];
            if (i < 9 || hold_stop) repeat (CPB) @(negedge SYS_CLK);
        end
    endtask

    // Returns once the last stop bit is on the line, before the DUT
    // reaches its centre, so the response strobe is not missed.
    task automatic send_reply(input frame_t f, input int bad_stop);
        for (int b = 0; b < 10; b++) begin
            send_byte(f[b], (b == bad_stop) ? 1'b0 : 1'b1, (b < 9) ? 1'b1 : 1'b0);
            if (b == bad_stop) begin
                UART_RXD = 1'b1;
                repeat (CPB) @(negedge SYS_CLK);
            end
        end
    endtask

    task automatic check_rsp(input string tag, input int limit, input logic [1:0] eerr,
                             input logic [31:0] edata, input logic check_data, output int at);
        int n;
        n = 0;
        while (RSP_VALID !== 1'b1 && n < limit) begin
            @(negedge SYS_CLK);
            n++;
        end
        at = cyc;
        chk({tag, "_rsp_valid"}, RSP_VALID, 1'b1);
        chk({tag, "_err"}, RSP_ERR, eerr);
        if (check_data) chk({tag, "_data"}, RSP_DATA, edata);
        chk({tag, "_ready_in_done"}, CMD_READY, 1'b0);
        @(negedge SYS_CLK);
        chk({tag, "_pulse_width"}, RSP_VALID, 1'b0);
        chk({tag, "_ready_back"}, CMD_READY, 1'b1);
        repeat (5) @(negedge SYS_CLK);
        chk({tag, "_err_hold"}, RSP_ERR, eerr);
        if (check_data) chk({tag, "_data_hold"}, RSP_DATA, edata);
    endtask

    initial begin
        int a;
        int at;
        int vcount;
        frame_t f;

        // ---------------- reset values ----------------
        repeat (3) @(negedge SYS_CLK);
        chk("rst_ready", CMD_READY, 1'b1);
        chk("rst_rsp_valid", RSP_VALID, 1'b0);
        chk("rst_rsp_data", RSP_DATA, 32'h0);
        chk("rst_rsp_err", RSP_ERR, 2'd0);
        chk("rst_txd", UART_TXD, 1'b1);
        SYS_RST = 1'b0;
        @(negedge SYS_CLK);

        // ---------------- RX activity while idle ----------------
        UART_RXD = 1'b0;
        repeat (4) @(negedge SYS_CLK);
        UART_RXD = 1'b1;
        repeat (CPB) @(negedge SYS_CLK);
        send_byte(8'h5A, 1'b1, 1'b1);
        repeat (2 * CPB) @(negedge SYS_CLK);
        chk("idle_rx_no_rsp", RSP_VALID, 1'b0);

        // ---------------- write with echoed reply ----------------
        issue(1'b0, 32'hAABBCCDD, 32'h11223344, a);
        f = '{8'h5A, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44, 8'hA5};
        check_frame(a, f, "wr");
        send_reply(f, -1);
        check_rsp("wr", 4 * CPB, 2'd0, 32'h11223344, 1'b1, at);

        // ---------------- read, glitch before the reply ----------------
        issue(1'b1, 32'h12345678, 32'hAABBCCDD, a);
        f = '{8'h5B, 8'h12, 8'h34, 8'h56, 8'h78, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hA4};
        check_frame(a, f, "rd");
        UART_RXD = 1'b0;
        repeat (4) @(negedge SYS_CLK);
        UART_RXD = 1'b1;
        repeat (2 * CPB) @(negedge SYS_CLK);
        f = '{8'h5B, 8'h12, 8'h34, 8'h56, 8'h78, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hA4};
        send_reply(f, -1);
        check_rsp("rd", 4 * CPB, 2'd0, 32'hDEADBEEF, 1'b1, at);

        // ---------------- write with no reply: timeout ----------------
        issue(1'b0, 32'h00000010, 32'h00000020, a);
        check_rsp("timeout", 100 * CPB + TO + 100, 2'd1, 32'h0, 1'b1, at);
        // Last stop bit ends with cycle a+100*CPB; strobe TO cycles later
        chk("timeout_latency", 32'(at - a), 32'(100 * CPB + TO + 1));

        // ---------------- read reply with wrong trailer ----------------
        issue(1'b1, 32'h12345678, 32'h0, a);
        wait_cyc(a + 100 * CPB);
        f = '{8'h5B, 8'h12, 8'h34, 8'h56, 8'h78, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hA5};
        send_reply(f, -1);
        check_rsp("bad_trailer", 4 * CPB, 2'd2, 32'h0, 1'b0, at);

        // ---------------- read reply with stop bit 0 on byte 3 ----------------
        issue(1'b1, 32'h12345678, 32'h0, a);
        wait_cyc(a + 100 * CPB);
        f = '{8'h5B, 8'h12, 8'h34, 8'h56, 8'h78, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hA4};
        send_reply(f, 3);
        check_rsp("bad_stop", 4 * CPB, 2'd2, 32'h0, 1'b0, at);

        // ---------------- reset during byte 4 of SEND ----------------
        issue(1'b0, 32'h01020304, 32'hCAFEF00D, a);
        wait_cyc(a + 1 + 40 * CPB + 2);
        chk("mid_txd_start_bit", UART_TXD, 1'b0);
        SYS_RST = 1'b1;
        @(negedge SYS_CLK);
        chk("mid_rst_txd", UART_TXD, 1'b1);
        chk("mid_rst_ready", CMD_READY, 1'b1);
        chk("mid_rst_rsp_valid", RSP_VALID, 1'b0);
        SYS_RST = 1'b0;
        vcount = 0;
        for (int i = 0; i < 60 * CPB; i++) begin
            @(negedge SYS_CLK);
            if (RSP_VALID === 1'b1) vcount++;
            if (UART_TXD !== 1'b1) vcount++;
        end
        chk("mid_rst_quiet", 32'(vcount), 32'h0);

        // ---------------- following write frames correctly ----------------
        issue(1'b0, 32'h0F0E0D0C, 32'h55AA00FF, a);
        f = '{8'h5A, 8'h0F, 8'h0E, 8'h0D, 8'h0C, 8'h55, 8'hAA, 8'h00, 8'hFF, 8'hA5};
        check_frame(a, f, "post_rst");
        send_reply(f, -1);
        check_rsp("post_rst", 4 * CPB, 2'd0, 32'h55AA00FF, 1'b1, at);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_cmd_client.md
Name: uart_cmd_client

Overview:
- UART command initiator: the host end of the cmd_server serial protocol.
- Takes one OPB read/write request on a valid/ready interface and serialises it as a 10-byte command frame on UART_TXD.
- Collects the 10-byte reply on UART_RXD, validates it and returns read data plus status.
- Used as an on-chip debug master and as a synthesizable stimulus source for cmd_server regression.

Parameters:
- CLKS_PER_BIT, 868, SYS_CLK cycles per UART bit (100 MHz / 115200).
- TIMEOUT_CLKS, 2000000, max cycles from end of the last TX stop bit to the 10th reply byte's stop bit (20 ms).

Ports:
- SYS_CLK  in  1  system clock, 100 MHz
- SYS_RST  in  1  synchronous active-high reset
- CMD_VALID  in  1  request valid
- CMD_READY  out  1  block idle, accepts request
- CMD_RW  in  1  0 = write (header 0x5A), 1 = read (header 0x5B)
- CMD_ADDR  in  32  OPB address
- CMD_WDATA  in  32  write data; sent but ignored by server on reads
- RSP_VALID  out  1  one-cycle pulse, response available
- RSP_DATA  out  32  data field of reply (read data, or echoed write data)
- RSP_ERR  out  2  0 ok, 1 timeout, 2 frame error
- UART_TXD  out  1  serial out, idle high
- UART_RXD  in  1  serial in, asynchronous

Behaviour:
- Reset values: CMD_READY=1, RSP_VALID=0, RSP_DATA=0, RSP_ERR=0, UART_TXD=1, FSM=IDLE. Reset mid-frame aborts immediately, with TXD forced high on the next edge.
- Handshake: request accepted on the cycle CMD_VALID & CMD_READY. CMD_RW, CMD_ADDR and CMD_WDATA are latched then. CMD_READY drops the next cycle and returns high the cycle after RSP_VALID.
- Frame bytes, in order:
  - header H;
  - ADDR[31:24], [23:16], [15:8], [7:0];
  - WDATA[31:24] .. [7:0];
  - trailer ~H (0xA5 for write, 0xA4 for read).
- UART format: 8N1, LSB first, start 0, stop 1, each bit exactly CLKS_PER_BIT cycles.
  - The first start bit begins the cycle after acceptance.
  - Bytes are back-to-back, no extra idle between stop and next start.
- FSM states: IDLE -> SEND (10 bytes) -> WAIT_RSP (10 bytes) -> DONE -> IDLE.
  - DONE lasts one cycle and asserts RSP_VALID.
- RX path:
  - 2-FF synchroniser on UART_RXD.
  - Start detected on a synchronised falling edge; confirmed low at half-bit, else ignored.
  - Data sampled at bit centres; stop bit sampled at centre.
  - Stop=0 is a framing error.
- RX activity outside WAIT_RSP is ignored, and the RX byte counter is cleared.
- Reply check:
  - byte0 == H;
  - bytes1-4 == latched address;
  - byte9 == ~H;
  - bytes5-8 (big-endian) -> RSP_DATA.
- Any mismatch or framing error sets RSP_ERR=2. Remaining bytes of the frame are still consumed or timed out; the first error wins.
- Timeout: a 32-bit counter starts at the end of the last TX stop bit. If it reaches TIMEOUT_CLKS before the 10th reply byte completes, the block goes to DONE with RSP_ERR=1 and RSP_DATA=0.
- Timeout and reply completion on the same cycle: completion wins.
- RSP_DATA and RSP_ERR hold their values until the next RSP_VALID.
- CMD_VALID held high continuously: the next request is accepted the cycle CMD_READY rises.

Test Plan:
- Write ADDR=0xAABBCCDD, WDATA=0x11223344 -> TXD bytes 5A AA BB CC DD 11 22 33 44 A5, each bit 868 clk.
  - Model replies with the same 10 bytes -> RSP_VALID pulse, RSP_ERR=0, RSP_DATA=0x11223344.
- Read ADDR=0x12345678, WDATA=0xAABBCCDD -> TXD 5B 12 34 56 78 AA BB CC DD A4.
  - Model replies 5B 12 34 56 78 DE AD BE EF A4 -> RSP_DATA=0xDEADBEEF, RSP_ERR=0.
- Write with no reply, TIMEOUT_CLKS=10000 -> RSP_VALID exactly 10000 clk after the last stop bit ends, RSP_ERR=1, then CMD_READY=1.
- Read reply with trailer 0xA5 instead of 0xA4 -> RSP_ERR=2. Separately, a reply with stop bit 0 on byte 3 -> RSP_ERR=2.
- Glitch on RXD (<CLKS_PER_BIT/2 low) during WAIT_RSP and during IDLE -> no byte counted, normal reply still completes with RSP_ERR=0.
- SYS_RST asserted during byte 4 of SEND -> next cycle TXD=1, CMD_READY=1, no RSP_VALID; a following write frames correctly.
